fdiv_d: RTL and testbench



---
 rtl/fdiv_d_pkg.sv | 53 +++++
 rtl/fdiv_d_divstage53.sv | 27 ++
 rtl/fdiv_d.sv | 151 +++++++++++++++
 tb/tb_fdiv_d.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fdiv_d_pkg.sv
// Shared types and constants for the iterative binary64 divider.
//
// Contents:
//   state_t             controller states
//   DoubleDiv_registers complete register set of the divider
//   DoubleDiv_r_reset   value loaded into that register set on i_rst
//   infOf()             signed infinity encoding
package fdiv_d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        NORM,
        PACK
    } state_t;

    localparam logic [10:0] EXP_MAX   = 11'h7FF;
    localparam logic [12:0] EXP_BIAS  = 13'd1023;
    localparam logic [5:0]  ITER_LAST = 6'd54;   // 55 quotient bits: cnt runs 54..0
    localparam logic [63:0] QNAN      = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        state_t      state;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] result;
        logic [52:0] mantB;
        logic [53:0] rem;
        logic [54:0] q;          // quotient bits; after NORM holds {mant, guard, sticky}
        logic [5:0]  cnt;
        logic [12:0] expQ;       // two's-complement biased exponent
        logic        sign;
        logic        zeroA;
        logic        zeroB;
        logic        infA;
        logic        infB;
        logic        nanA;
        logic        nanB;
        logic        illegalOp;
        logic        divByZero;
        logic        overflow;
        logic        valid;
        logic        busy;
    } DoubleDiv_registers;

    localparam DoubleDiv_registers DoubleDiv_r_reset = '{state: IDLE, default: '0};

    function automatic logic [63:0] infOf(input logic sign);
        return {sign, EXP_MAX, 52'd0};
    endfunction

endpackage

// File: rtl/fdiv_d_divstage53.sv
// One radix-2 restoring division step.
//
// Ports:
//   rem      in  54  partial remainder
//   divisor  in  53  divisor mantissa {1, frac}
//   remNext  out 54  remainder for the next step, already shifted left
//   qBit     out 1   quotient bit produced by this step
module divstage53 (
    input  logic [53:0] rem,
    input  logic [52:0] divisor,
    output logic [53:0] remNext,
    output logic        qBit
);

    logic [53:0] diff;
    logic [53:0] kept;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        diff    = rem - {1'b0, divisor};
        qBit    = (rem >= {1'b0, divisor});
        kept    = qBit ? diff : rem;
        // kept < divisor < 2^53, so the shift never drops a set bit.
        remNext = kept << 1;
    end

endmodule

// File: rtl/fdiv_d.sv
// Iterative IEEE-754 binary64 divider (a / b), restoring radix-2,
// round-to-nearest-even, denormal inputs and results flushed to zero.
// Fixed latency: o_valid rises 58 edges after the edge that accepts i_ena.
//
// Ports:
//   i_clk         in  1   clock
//   i_rst         in  1   synchronous active-high reset
//   i_ena         in  1   start a division (sampled only when idle)
//   i_a           in  64  dividend
//   i_b           in  64  divisor
//   o_res         out 64  quotient, held until the next result
//   o_illegal_op  out 1   NaN input, 0/0 or inf/inf
//   o_divbyzero   out 1   finite non-zero divided by zero
//   o_overflow    out 1   result exponent overflow
//   o_valid       out 1   one-cycle result strobe
//   o_busy        out 1   operation in flight
module fdiv_d
    import fdiv_d_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ena,
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic [63:0] o_res,
    output logic        o_illegal_op,
    output logic        o_divbyzero,
    output logic        o_overflow,
    output logic        o_valid,
    output logic        o_busy
);

    DoubleDiv_registers r;

    logic [53:0] remNext;
    logic        qBit;

    divstage53 u_stage (
        .rem     (r.rem),
        .divisor (r.mantB),
        .remNext (remNext),
        .qBit    (qBit)
    );

    // Rounding datapath, only meaningful in PACK where r.q = {mant, guard, sticky}.
    logic               roundUp;
    logic [52:0]        fracRounded;
    logic signed [12:0] expFinal;

    always_comb begin
        roundUp     = r.q[1] & (r.q[0] | r.q[2]);
        fracRounded = {1'b0, r.q[53:2]} + {52'd0, roundUp};
        // A carry out of the fraction leaves it all-zero: mantissa becomes 1.0.
        expFinal    = $signed(r.expQ) + $signed({12'd0, fracRounded[52]});
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r <= DoubleDiv_r_reset;
        end else begin
            r.valid <= 1'b0;
            case (r.state)
                IDLE: begin
                    if (i_ena) begin
                        r.a         <= i_a;
                        r.b         <= i_b;
                        r.busy      <= 1'b1;
                        r.illegalOp <= 1'b0;
                        r.divByZero <= 1'b0;
                        r.overflow  <= 1'b0;
                        r.state     <= PREP;
                    end
                end
                PREP: begin
                    r.sign  <= r.a[63] ^ r.b[63];
                    r.zeroA <= (r.a[62:52] == 11'd0);
                    r.zeroB <= (r.b[62:52] == 11'd0);
                    r.infA  <= (r.a[62:52] == EXP_MAX) && (r.a[51:0] == 52'd0);
                    r.infB  <= (r.b[62:52] == EXP_MAX) && (r.b[51:0] == 52'd0);
                    r.nanA  <= (r.a[62:52] == EXP_MAX) && (r.a[51:0] != 52'd0);
                    r.nanB  <= (r.b[62:52] == EXP_MAX) && (r.b[51:0] != 52'd0);
                    r.rem   <= {2'b01, r.a[51:0]};
                    r.mantB <= {1'b1, r.b[51:0]};
                    r.q     <= '0;
                    r.expQ  <= {2'b00, r.a[62:52]} - {2'b00, r.b[62:52]} + EXP_BIAS;
                    r.cnt   <= ITER_LAST;
                    r.state <= ITER;
                end
                ITER: begin
                    r.q   <= {r.q[53:0], qBit};
                    r.rem <= remNext;
                    r.cnt <= r.cnt - 6'd1;
                    if (r.cnt == 6'd0) begin
                        r.state <= NORM;
                    end
                end
                NORM: begin
                    // Quotient lies in (0.5, 2): align to a leading one and fold the
                    // remainder into sticky, leaving {mant[52:0], guard, sticky}.
                    if (r.q[54]) begin
                        r.q <= {r.q[54:1], r.q[0] | (r.rem != 54'd0)};
                    end else begin
                        r.q    <= {r.q[53:0], (r.rem != 54'd0)};
                        r.expQ <= r.expQ - 13'd1;
                    end
                    r.state <= PACK;
                end
                PACK: begin
                    if (r.nanA || r.nanB) begin
                        r.result    <= QNAN;
                        r.illegalOp <= 1'b1;
                    end else if ((r.zeroA && r.zeroB) || (r.infA && r.infB)) begin
                        r.result    <= QNAN;
                        r.illegalOp <= 1'b1;
                    end else if (r.infA) begin
                        r.result <= infOf(r.sign);
                    end else if (r.infB) begin
                        r.result <= {r.sign, 63'd0};
                    end else if (r.zeroB) begin
                        r.result    <= infOf(r.sign);
                        r.divByZero <= 1'b1;
                    end else if (r.zeroA) begin
                        r.result <= {r.sign, 63'd0};
                    end else if (expFinal >= 13'sd2047) begin
                        r.result   <= infOf(r.sign);
                        r.overflow <= 1'b1;
                    end else if (expFinal <= 13'sd0) begin
                        r.result <= {r.sign, 63'd0};
                    end else begin
                        r.result <= {r.sign, expFinal[10:0], fracRounded[51:0]};
                    end
                    r.valid <= 1'b1;
                    r.busy  <= 1'b0;
                    r.state <= IDLE;
                end
                default: begin
                    r.state <= IDLE;
                end
            endcase
        end
    end

    assign o_res        = r.result;
    assign o_illegal_op = r.illegalOp;
    assign o_divbyzero  = r.divByZero;
    assign o_overflow   = r.overflow;
    assign o_valid      = r.valid;
    assign o_busy       = r.busy;

endmodule

// File: tb/tb_fdiv_d.sv
// Self-checking bench for fdiv_d. A reference timeline (latency counter plus
// a quotient computed with real arithmetic) is compared against the DUT on
// every cycle; directed vectors additionally pin results to literals.
module tb_fdiv_d;

    localparam logic [63:0] QNAN  = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] THREE = 64'h4008_0000_0000_0000;
    localparam logic [63:0] FIVE  = 64'h4014_0000_0000_0000;
    localparam logic [63:0] SIX   = 64'h4018_0000_0000_0000;
    localparam logic [63:0] PINF  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] NINF  = 64'hFFF0_0000_0000_0000;

    // flags are packed as {illegal_op, divbyzero, overflow}
    typedef struct packed {
        logic [63:0] res;
        logic [2:0]  flags;
    } outcome_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_ena;
    logic [63:0] i_a;
    logic [63:0] i_b;
    logic [63:0] o_res;
    logic        o_illegal_op;
    logic        o_divbyzero;
    logic        o_overflow;
    logic        o_valid;
    logic        o_busy;

    int checks    = 0;
    int passed    = 0;
    int validSeen = 0;
    bit cmpOn     = 1'b0;

    fdiv_d dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ena        (i_ena),
        .i_a          (i_a),
        .i_b          (i_b),
        .o_res        (o_res),
        .o_illegal_op (o_illegal_op),
        .o_divbyzero  (o_divbyzero),
        .o_overflow   (o_overflow),
        .o_valid      (o_valid),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Quotient from the host's IEEE division (round-to-nearest-even), with
    // denormal operands treated as zero and subnormal quotients flushed.
    function automatic outcome_t divModel(input logic [63:0] a, input logic [63:0] b);
        outcome_t    o;
        logic        sgn;
        logic        zA, zB, infA, infB, nanA, nanB;
        logic [63:0] bits;
        real         q;
        sgn  = a[63] ^ b[63];
        zA   = (a[62:52] == 11'd0);
        zB   = (b[62:52] == 11'd0);
        infA = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
        infB = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
        nanA = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
        nanB = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
        o.flags = 3'b000;
        if (nanA || nanB) begin
            o.res = QNAN; o.flags = 3'b100;
        end else if ((zA && zB) || (infA && infB)) begin
            o.res = QNAN; o.flags = 3'b100;
        end else if (infA) begin
            o.res = {sgn, 11'h7FF, 52'd0};
        end else if (infB) begin
            o.res = {sgn, 63'd0};
        end else if (zB) begin
            o.res = {sgn, 11'h7FF, 52'd0}; o.flags = 3'b010;
        end else if (zA) begin
            o.res = {sgn, 63'd0};
        end else begin
            q    = $bitstoreal({1'b0, a[62:0]}) / $bitstoreal({1'b0, b[62:0]});
            bits = $realtobits(q);
            if (bits[62:52] == 11'h7FF) begin
                o.res = {sgn, 11'h7FF, 52'd0}; o.flags = 3'b001;
            end else if (bits[62:52] == 11'd0) begin
                o.res = {sgn, 63'd0};
            end else begin
                o.res = {sgn, bits[62:0]};
            end
        end
        return o;
    endfunction

    // Reference timeline: busy for 58 edges after acceptance, then a result strobe.
    logic        mBusy  = 1'b0;
    logic        mValid = 1'b0;
    logic [63:0] mRes   = '0;
    logic [2:0]  mFlags = '0;
    int          mAge   = 0;
    outcome_t    mPend;

    always @(posedge i_clk) begin
        if (i_rst) begin
            mBusy = 1'b0; mValid = 1'b0; mRes = '0; mFlags = '0; mAge = 0;
        end else begin
            mValid = 1'b0;
            if (mBusy) begin
                mAge++;
                if (mAge == 58) begin
                    mBusy = 1'b0; mValid = 1'b1; mRes = mPend.res; mFlags = mPend.flags;
                end
            end else if (i_ena) begin
                mBusy = 1'b1; mAge = 0; mPend = divModel(i_a, i_b); mFlags = '0;
            end
        end
    end

    always @(negedge i_clk) begin
        if (cmpOn) begin
            check("cyc busy", 64'(o_busy), 64'(mBusy));
            check("cyc valid", 64'(o_valid), 64'(mValid));
            check("cyc res", o_res, mRes);
            check("cyc flags", 64'({o_illegal_op, o_divbyzero, o_overflow}), 64'(mFlags));
            if (o_valid) validSeen++;
        end
    end

    task automatic waitValid(inout int waits);
        while (!o_valid && waits < 100) begin
            @(negedge i_clk);
            waits++;
        end
    endtask

    // Starts an operation at a negedge, waits for the strobe and checks it.
    task automatic runOp(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] expRes, input logic [2:0] expFl);
        int waits;
        i_a = a; i_b = b; i_ena = 1'b1;
        @(negedge i_clk);
        i_ena = 1'b0;
        waits = 1;
        waitValid(waits);
        if (!o_valid) begin
            check({name, " timeout"}, 64'(o_valid), 64'd1);
        end else begin
            check({name, " latency"}, 64'(waits - 1), 64'd58);
            check({name, " res"}, o_res, expRes);
            check({name, " flags"}, 64'({o_illegal_op, o_divbyzero, o_overflow}), 64'(expFl));
            check({name, " model"}, mRes, expRes);
        end
        @(negedge i_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v0;
        int waits;
        i_rst = 1'b1; i_ena = 1'b0; i_a = '0; i_b = '0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check("reset res", o_res, 64'd0);
        check("reset ctl", 64'({o_valid, o_busy, o_illegal_op, o_divbyzero, o_overflow}), 64'd0);
        cmpOn = 1'b1;
        @(negedge i_clk);

        runOp("6/2",       SIX, TWO, THREE, 3'b000);
        runOp("-6/2",      64'hC018_0000_0000_0000, TWO, 64'hC008_0000_0000_0000, 3'b000);
        runOp("1/3",       ONE, THREE, 64'h3FD5_5555_5555_5555, 3'b000);
        runOp("1/(1+ulp)", ONE, 64'h3FF0_0000_0000_0001, 64'h3FEF_FFFF_FFFF_FFFE, 3'b000);
        runOp("5/3",       FIVE, THREE, 64'h3FFA_AAAA_AAAA_AAAB, 3'b000);
        runOp("-1/0",      64'hBFF0_0000_0000_0000, 64'd0, NINF, 3'b010);
        runOp("0/0",       64'd0, 64'd0, QNAN, 3'b100);
        runOp("nan/1",     64'h7FF0_0000_0000_0001, ONE, QNAN, 3'b100);
        runOp("1/-nan",    ONE, 64'hFFF8_0000_0000_0000, QNAN, 3'b100);
        runOp("inf/inf",   PINF, PINF, QNAN, 3'b100);
        runOp("inf/-2",    PINF, 64'hC000_0000_0000_0000, NINF, 3'b000);
        runOp("2/inf",     TWO, PINF, 64'd0, 3'b000);
        runOp("1/-inf",    ONE, NINF, 64'h8000_0000_0000_0000, 3'b000);
        runOp("0/-5",      64'd0, 64'hC014_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b000);
        runOp("denorm/1",  64'd1, ONE, 64'd0, 3'b000);
        runOp("max/0.5",   64'h7FEF_FFFF_FFFF_FFFF, 64'h3FE0_0000_0000_0000, PINF, 3'b001);
        runOp("minnorm/2", 64'h0010_0000_0000_0000, TWO, 64'd0, 3'b000);

        // i_ena while busy is ignored; i_ena in the strobe cycle is accepted.
        v0 = validSeen;
        i_a = SIX; i_b = TWO; i_ena = 1'b1;
        @(negedge i_clk);
        i_a = ONE; i_b = THREE;
        @(negedge i_clk);
        i_ena = 1'b0;
        repeat (27) @(negedge i_clk);
        i_a = FIVE; i_b = THREE; i_ena = 1'b1;
        @(negedge i_clk);
        i_ena = 1'b0;
        waits = 30;
        waitValid(waits);
        check("hs first latency", 64'(waits - 1), 64'd58);
        check("hs first res", o_res, THREE);
        i_a = ONE; i_b = THREE; i_ena = 1'b1;
        @(negedge i_clk);
        i_ena = 1'b0;
        waits = 1;
        waitValid(waits);
        check("hs second latency", 64'(waits - 1), 64'd58);
        check("hs second res", o_res, 64'h3FD5_5555_5555_5555);
        @(negedge i_clk);
        #1;
        check("hs strobes", 64'(validSeen - v0), 64'd2);

        // Reset mid-operation abandons the division without a strobe.
        i_a = SIX; i_b = TWO; i_ena = 1'b1;
        @(negedge i_clk);
        i_ena = 1'b0;
        repeat (19) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rst busy", 64'(o_busy), 64'd0);
        check("rst res", o_res, 64'd0);
        v0 = validSeen;
        repeat (70) @(negedge i_clk);
        #1;
        check("rst no strobe", 64'(validSeen - v0), 64'd0);
        @(negedge i_clk);
        runOp("2/2", TWO, TWO, ONE, 3'b000);

        cmpOn = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
